msm_stream_loader: RTL and testbench
====================================

MSM_STREAM_LOADER -- requirements
Module: msm_stream_loader

Interface
REQ-001 Parameter LENGTH, default 100: number of (point, scalar) pairs per MSM job.
REQ-002 Parameter SCALAR_WIDTH and P_WIDTH come from package elliptic_curve_structs; they are not redeclared locally.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 Reset_n  in  1  asynchronous active-low reset.
REQ-006 in_data  in  P_WIDTH  inbound word: Gx, Gy or scalar.
REQ-007 in_valid  in  1  in_data is valid this cycle.
REQ-008 in_ready  out  1  loader accepts in_data this cycle.
REQ-009 G  out  curve_point_t[LENGTH]  point bank driven to the MSM engine.
REQ-010 x  out  SCALAR_WIDTH[LENGTH]  scalar bank driven to the MSM engine.
REQ-011 msm_reset  out  1  active-high reset/start to the MSM engine.
REQ-012 msm_done  in  1  engine Done.
REQ-013 msm_R  in  curve_point_t  engine result.
REQ-014 out_data  out  P_WIDTH  result word: Rx, then Ry.
REQ-015 out_valid  out  1  out_data is valid.
REQ-016 out_ready  in  1  sink accepts out_data.

Function
REQ-017 FSM states SHALL be LOAD, START, RUN, SEND_X and SEND_Y.
REQ-018 In LOAD, in_ready SHALL be 1; all other states hold in_ready at 0.
REQ-019 A word is accepted iff in_valid && in_ready at a rising edge.
REQ-020 Inbound word order per element SHALL be Gx, Gy, scalar; elements arrive in index order 0..LENGTH-1.
REQ-021 The scalar SHALL be taken as in_data[SCALAR_WIDTH-1:0]; upper bits are ignored.
REQ-022 Phase counter (0..2) SHALL wrap to 0 after the scalar word; element index SHALL increment on that wrap.
REQ-023 Acceptance of the scalar word of element LENGTH-1 SHALL move LOAD->START on the next edge, and SHALL reset index and phase to 0.
REQ-024 START SHALL last exactly 2 cycles with msm_reset=1, then move to RUN.
REQ-025 msm_reset SHALL be 1 in LOAD and START, and 0 in RUN, SEND_X and SEND_Y, so the engine only runs on a fully loaded bank.
REQ-026 RUN: on msm_done=1, msm_R SHALL be captured into an internal register and the FSM moves to SEND_X.
REQ-027 msm_done SHALL be ignored outside RUN.
REQ-028 SEND_X: out_valid=1 and out_data=captured R.x; on out_ready the FSM moves to SEND_Y.
REQ-029 SEND_Y: out_valid=1 and out_data=captured R.y; on out_ready the FSM moves to LOAD for the next job.
REQ-030 out_data SHALL hold stable while out_valid && !out_ready.
REQ-031 out_valid SHALL be 0 in LOAD, START and RUN.
REQ-032 G and x SHALL hold their contents from START until the next accepted word of the following job; overwriting is per-word, with no bulk clear.
REQ-033 Idle in_valid gaps in LOAD SHALL NOT advance the counters.

Reset
REQ-034 On Reset_n=0: state=LOAD, index=0, phase=0, in_ready=0 while reset is asserted, msm_reset=1, out_valid=0, out_data=0, captured R=0; G and x are cleared to 0.
REQ-035 Reset asserted mid-job (any state) SHALL abort the job immediately; the first word accepted after release is Gx of element 0.

Structure
REQ-036 The FSM state enum and curve_point_t SHALL live in elliptic_curve_structs, alongside P_WIDTH and SCALAR_WIDTH.
REQ-037 The block is a single module with no sub-modules.
REQ-038 The MSM engine (msm_naive) is instantiated by the integrating top level, not inside this block.

Verification
REQ-039 Bench SHALL use LENGTH=4 with msm_naive plus the test_Gx/Gy/x/Rx/Ry vector files.
REQ-040 Full job: stream 12 words with in_valid held high, then out_ready=1 -> msm_reset deasserts 2 cycles after the 12th word; out_data equals test_Rx[0] then test_Ry[0] on consecutive cycles.
REQ-041 Gapped input: in_valid toggles 1,0,1,0 -> 12 accepts are still required, and the bank contents match the same-index values.
REQ-042 Backpressure: out_ready=0 for 5 cycles in SEND_X -> out_valid stays 1 and out_data stays Rx; no Ry appears early.
REQ-043 Wide scalar: scalar word 0xFFFF...F with SCALAR_WIDTH < P_WIDTH -> x[i] equals all-ones of SCALAR_WIDTH only.
REQ-044 Reset mid-RUN: Reset_n low for 1 cycle -> out_valid=0 and msm_reset=1 immediately; a second full job then produces the correct R.
REQ-045 Back-to-back jobs: two jobs with different vectors -> each R matches its own expected values.

Source files
------------

// File: rtl/msm_stream_loader_pkg.sv
// rtl/msm_stream_loader_pkg.sv - curve point types, widths and loader FSM encodings
package elliptic_curve_structs;

    localparam int P_WIDTH      = 16;
    localparam int SCALAR_WIDTH = 8;

    // Number of cycles the engine is held in reset after the bank is full.
    localparam int START_CYCLES = 2;

    typedef struct packed {
        logic [P_WIDTH-1:0] x;
        logic [P_WIDTH-1:0] y;
    } curve_point_t;

    typedef enum logic [2:0] {
        LOAD,
        START,
        RUN,
        SEND_X,
        SEND_Y
    } loader_state_t;

    // Position of the next inbound word inside one (point, scalar) element.
    typedef enum logic [1:0] {
        PH_GX,
        PH_GY,
        PH_SC
    } phase_t;

    // Scalars travel on the full-width bus; only the low bits are meaningful.
    function automatic logic [SCALAR_WIDTH-1:0] scalar_of(input logic [P_WIDTH-1:0] w);
        return w[SCALAR_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/msm_stream_loader_if.sv
// rtl/msm_stream_loader_if.sv - inbound word stream and outbound result stream of the loader
interface msm_stream_loader_if
    import elliptic_curve_structs::*;
();

    logic [P_WIDTH-1:0] in_data;
    logic               in_valid;
    logic               in_ready;

    logic [P_WIDTH-1:0] out_data;
    logic               out_valid;
    logic               out_ready;

    // Loader side: consumes the inbound stream, produces the result stream.
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready
    );

    // Host side: produces the inbound stream, consumes the result stream.
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/msm_stream_loader.sv
// rtl/msm_stream_loader.sv - streams (G, x) pairs into a bank, starts the MSM engine, returns R
module msm_stream_loader
    import elliptic_curve_structs::*;
#(
    parameter int LENGTH = 100
) (
    input  logic                    clk,
    input  logic                    Reset_n,
    msm_stream_loader_if.slave      sif,
    output curve_point_t            G [LENGTH],
    output logic [SCALAR_WIDTH-1:0] x [LENGTH],
    output logic                    msm_reset,
    input  logic                    msm_done,
    input  curve_point_t            msm_R
);

    localparam int               IDX_W      = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(LENGTH - 1);
    localparam logic [1:0]       START_LAST = 2'(START_CYCLES - 1);

    loader_state_t state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    phase_t phase_q, phase_d;
    logic [1:0] start_cnt_q, start_cnt_d;

    logic in_ready_q, in_ready_d;
    logic msm_reset_q, msm_reset_d;
    logic out_valid_q, out_valid_d;
    logic [P_WIDTH-1:0] out_data_q, out_data_d;
    curve_point_t r_q, r_d;

    curve_point_t bank_g_q [LENGTH];
    curve_point_t bank_g_d [LENGTH];
    logic [SCALAR_WIDTH-1:0] bank_x_q [LENGTH];
    logic [SCALAR_WIDTH-1:0] bank_x_d [LENGTH];

    logic accept;

    assign sif.in_ready  = in_ready_q;
    assign sif.out_valid = out_valid_q;
    assign sif.out_data  = out_data_q;
    assign msm_reset     = msm_reset_q;
    assign G             = bank_g_q;
    assign x             = bank_x_q;

    // Next-state logic: word placement, job sequencing and the registered handshake outputs.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        phase_d     = phase_q;
        start_cnt_d = start_cnt_q;
        r_d         = r_q;
        out_data_d  = out_data_q;
        bank_g_d    = bank_g_q;
        bank_x_d    = bank_x_q;
        accept      = sif.in_valid && in_ready_q;

        case (state_q)
            LOAD: begin
                if (accept) begin
                    case (phase_q)
                        PH_GX: begin
                            bank_g_d[idx_q].x = sif.in_data;
                            phase_d           = PH_GY;
                        end
                        PH_GY: begin
                            bank_g_d[idx_q].y = sif.in_data;
                            phase_d           = PH_SC;
                        end
                        PH_SC: begin
                            bank_x_d[idx_q] = scalar_of(sif.in_data);
                            phase_d         = PH_GX;
                            if (idx_q == LAST_IDX) begin
                                idx_d       = '0;
                                start_cnt_d = '0;
                                state_d     = START;
                            end else begin
                                idx_d = idx_q + 1'b1;
                            end
                        end
                        default: phase_d = PH_GX;
                    endcase
                end
            end
            START: begin
                if (start_cnt_q == START_LAST) begin
                    state_d = RUN;
                end else begin
                    start_cnt_d = start_cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (msm_done) begin
                    r_d        = msm_R;
                    out_data_d = msm_R.x;
                    state_d    = SEND_X;
                end
            end
            SEND_X: begin
                if (sif.out_ready) begin
                    out_data_d = r_q.y;
                    state_d    = SEND_Y;
                end
            end
            SEND_Y: begin
                if (sif.out_ready) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase

        // Outputs are decoded from the next state so they change together with it.
        in_ready_d  = (state_d == LOAD);
        msm_reset_d = (state_d == LOAD) || (state_d == START);
        out_valid_d = (state_d == SEND_X) || (state_d == SEND_Y);
    end

    // State registers; reset aborts any job and clears the bank and the captured result.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= LOAD;
            idx_q       <= '0;
            phase_q     <= PH_GX;
            start_cnt_q <= '0;
            in_ready_q  <= 1'b0;
            msm_reset_q <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            r_q         <= '0;
            for (int i = 0; i < LENGTH; i++) begin
                bank_g_q[i] <= '0;
                bank_x_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            phase_q     <= phase_d;
            start_cnt_q <= start_cnt_d;
            in_ready_q  <= in_ready_d;
            msm_reset_q <= msm_reset_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            r_q         <= r_d;
            bank_g_q    <= bank_g_d;
            bank_x_q    <= bank_x_d;
        end
    end

endmodule

// File: tb/tb_msm_stream_loader.sv
// tb/tb_msm_stream_loader.sv - scoreboard bench for msm_stream_loader with a behavioural MSM engine
module tb_msm_stream_loader;
    import elliptic_curve_structs::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic Reset_n = 1'b0;

    msm_stream_loader_if sif ();

    curve_point_t            G [N];
    logic [SCALAR_WIDTH-1:0] x [N];
    logic                    msm_reset;
    logic                    msm_done = 1'b0;
    curve_point_t            msm_R = '0;

    int checks = 0;
    int errors = 0;
    int eng_cnt = 0;

    logic [15:0] gx [N];
    logic [15:0] gy [N];
    logic [15:0] sc [N];
    logic [15:0] exp_q [$];

    logic [15:0] eg_x [N];
    logic [15:0] eg_y [N];
    logic [7:0]  eg_s [N];

    msm_stream_loader #(.LENGTH(N)) dut (
        .clk       (clk),
        .Reset_n   (Reset_n),
        .sif       (sif),
        .G         (G),
        .x         (x),
        .msm_reset (msm_reset),
        .msm_done  (msm_done),
        .msm_R     (msm_R)
    );

    always #5 clk = ~clk;

    // Reference result: position-weighted so element order and word placement both matter.
    function automatic curve_point_t calc_r(input logic [15:0] ax [N], input logic [15:0] ay [N],
                                            input logic [7:0] s [N]);
        curve_point_t r;
        int sx;
        int sy;
        sx = 0;
        sy = 0;
        for (int i = 0; i < N; i++) begin
            sx = sx + int'(ax[i]) * int'(s[i]) * (i + 1);
            sy = sy + int'(ax[i] ^ ay[i]) * (int'(s[i]) + i + 3);
        end
        r.x = 16'(sx ^ 32'h5a5a);
        r.y = 16'(sy + 7);
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) begin
            eg_x[i] = G[i].x;
            eg_y[i] = G[i].y;
            eg_s[i] = x[i];
        end
    end

    // Engine stand-in: runs 6 cycles after msm_reset drops, then holds Done until reset.
    always @(posedge clk) begin
        if (msm_reset) begin
            eng_cnt  <= 0;
            msm_done <= 1'b0;
        end else if (!msm_done) begin
            eng_cnt <= eng_cnt + 1;
            if (eng_cnt == 5) begin
                msm_done <= 1'b1;
                msm_R    <= calc_r(eg_x, eg_y, eg_s);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic fill_random();
        for (int i = 0; i < N; i++) begin
            gx[i] = 16'($urandom);
            gy[i] = 16'($urandom);
            sc[i] = 16'($urandom);
        end
    endtask

    task automatic push_expected();
        logic [7:0] ts [N];
        curve_point_t r;
        for (int i = 0; i < N; i++) ts[i] = sc[i][7:0];
        r = calc_r(gx, gy, ts);
        exp_q.push_back(r.x);
        exp_q.push_back(r.y);
    endtask

    // Called just after a falling edge; returns just after the falling edge following acceptance.
    task automatic push_word(input logic [15:0] w);
        int t;
        sif.in_data  = w;
        sif.in_valid = 1'b1;
        t = 0;
        while (!sif.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!sif.in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_accept_timeout in_ready=%b exp 1", sif.in_ready);
        end
        @(negedge clk);
        sif.in_valid = 1'b0;
    endtask

    task automatic send_job(input bit gapped);
        logic [15:0] w;
        push_expected();
        for (int i = 0; i < N; i++) begin
            for (int ph = 0; ph < 3; ph++) begin
                w = (ph == 0) ? gx[i] : (ph == 1) ? gy[i] : sc[i];
                if (gapped && i == N - 1 && ph == 2) begin
                    checks++;
                    if (sif.in_ready !== 1'b1) begin
                        errors++;
                        $display("FAIL early_start in_ready=%b exp 1 before last word", sif.in_ready);
                    end
                end
                push_word(w);
                if (gapped && !(i == N - 1 && ph == 2)) @(negedge clk);
            end
        end
        checks++;
        if (sif.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_end in_ready=%b exp 0 after last word", sif.in_ready);
        end
    endtask

    task automatic check_bank(input string tag);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (G[i].x !== gx[i] || G[i].y !== gy[i] || x[i] !== sc[i][7:0]) begin
                errors++;
                $display("FAIL %s_bank[%0d] got %h/%h/%h exp %h/%h/%h", tag, i,
                         G[i].x, G[i].y, x[i], gx[i], gy[i], sc[i][7:0]);
            end
        end
    endtask

    task automatic drain_result(input string tag);
        int t;
        logic [15:0] e;
        sif.out_ready = 1'b1;
        t = 0;
        while (!sif.out_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!sif.out_valid) begin
            errors++;
            $display("FAIL %s_result_timeout out_valid=%b exp 1", tag, sif.out_valid);
            sif.out_ready = 1'b0;
            exp_q.delete();
            return;
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0;
        checks++;
        if (sif.out_data !== e) begin
            errors++;
            $display("FAIL %s_rx got %h exp %h", tag, sif.out_data, e);
        end
        @(negedge clk);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0;
        checks++;
        if (sif.out_valid !== 1'b1 || sif.out_data !== e) begin
            errors++;
            $display("FAIL %s_ry got valid=%b data=%h exp valid=1 data=%h", tag, sif.out_valid, sif.out_data, e);
        end
        @(negedge clk);
        checks++;
        if (sif.out_valid !== 1'b0 || sif.in_ready !== 1'b1 || msm_reset !== 1'b1) begin
            errors++;
            $display("FAIL %s_back_to_load got valid=%b ready=%b msm_reset=%b exp 0/1/1",
                     tag, sif.out_valid, sif.in_ready, msm_reset);
        end
        sif.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (sif.in_ready !== 1'b0 || msm_reset !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctrl got in_ready=%b msm_reset=%b exp 0/1", sif.in_ready, msm_reset);
        end
        checks++;
        if (sif.out_valid !== 1'b0 || sif.out_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_out got valid=%b data=%h exp 0/0000", sif.out_valid, sif.out_data);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (G[i] !== '0 || x[i] !== '0) begin
                errors++;
                $display("FAIL reset_bank[%0d] got %h/%h exp 0", i, G[i], x[i]);
            end
        end
        Reset_n = 1'b1;
    endtask

    task automatic test_full_job();
        fill_random();
        send_job(1'b0);
        checks++;
        if (msm_reset !== 1'b1) begin
            errors++;
            $display("FAIL start_c0 msm_reset=%b exp 1", msm_reset);
        end
        @(negedge clk);
        checks++;
        if (msm_reset !== 1'b1) begin
            errors++;
            $display("FAIL start_c1 msm_reset=%b exp 1", msm_reset);
        end
        @(negedge clk);
        checks++;
        if (msm_reset !== 1'b0) begin
            errors++;
            $display("FAIL run_entry msm_reset=%b exp 0", msm_reset);
        end
        check_bank("full");
        drain_result("full");
    endtask

    task automatic test_gapped();
        fill_random();
        send_job(1'b1);
        check_bank("gapped");
        drain_result("gapped");
    endtask

    task automatic test_backpressure();
        int t;
        fill_random();
        send_job(1'b0);
        sif.out_ready = 1'b0;
        t = 0;
        while (!sif.out_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (sif.out_valid !== 1'b1 || exp_q.size() == 0 || sif.out_data !== exp_q[0]) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got valid=%b data=%h exp valid=1 data=%h",
                         c, sif.out_valid, sif.out_data, (exp_q.size() > 0) ? exp_q[0] : 16'h0);
            end
            @(negedge clk);
        end
        drain_result("bp");
    endtask

    task automatic test_wide_scalar();
        fill_random();
        for (int i = 0; i < N; i++) sc[i] = 16'hFFFF;
        send_job(1'b0);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (x[i] !== 8'hFF) begin
                errors++;
                $display("FAIL wide_scalar[%0d] got %h exp ff", i, x[i]);
            end
        end
        drain_result("wide");
    endtask

    task automatic test_reset_mid_run();
        int t;
        fill_random();
        send_job(1'b0);
        t = 0;
        while (msm_reset !== 1'b0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (msm_reset !== 1'b0) begin
            errors++;
            $display("FAIL mid_run_reach msm_reset=%b exp 0", msm_reset);
        end
        Reset_n = 1'b0;
        #1;
        checks++;
        if (sif.out_valid !== 1'b0 || msm_reset !== 1'b1 || sif.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_run_abort got valid=%b msm_reset=%b ready=%b exp 0/1/0",
                     sif.out_valid, msm_reset, sif.in_ready);
        end
        checks++;
        if (G[0] !== '0 || x[N-1] !== '0) begin
            errors++;
            $display("FAIL mid_run_clear got %h/%h exp 0", G[0], x[N-1]);
        end
        @(negedge clk);
        Reset_n = 1'b1;
        exp_q.delete();
        fill_random();
        send_job(1'b0);
        check_bank("after_reset");
        drain_result("after_reset");
    endtask

    task automatic test_back_to_back();
        fill_random();
        send_job(1'b0);
        drain_result("b2b_a");
        fill_random();
        send_job(1'b0);
        check_bank("b2b_b");
        drain_result("b2b_b");
    endtask

    initial begin
        sif.in_data   = '0;
        sif.in_valid  = 1'b0;
        sif.out_ready = 1'b0;
        test_reset();
        test_full_job();
        test_gapped();
        test_backpressure();
        test_wide_scalar();
        test_reset_mid_run();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
